// File: rtl/dcache_repl_if.sv
// Touch/victim port between the dCache controller (master) and its replacement policy unit (slave).
interface dcache_repl_if #(
  parameter int WAYS = 4,
  parameter int SETS = 64
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;

  logic             touch_valid;
  logic             touch_fill;
  logic [IDX_W-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;
  logic             victim_req;
  logic [IDX_W-1:0] victim_set;
  logic [WAYS-1:0]  way_valid;
  logic             victim_valid;
  logic [WAY_W-1:0] victim_way;

  modport master (
    output touch_valid, touch_fill, touch_set, touch_way,
    output victim_req, victim_set, way_valid,
    input  victim_valid, victim_way
  );

  modport slave (
    input  touch_valid, touch_fill, touch_set, touch_way,
    input  victim_req, victim_set, way_valid,
    output victim_valid, victim_way
  );
endinterface

// File: rtl/dcache_repl_policy.sv
// Per-set victim selection (round-robin / tree PLRU / LFSR) with invalid-way priority.
// Latency: victim 1 cycle after victim_req; no backpressure, victim_way held until the next pulse.
module dcache_repl_policy #(
  parameter int          WAYS      = 4,
  parameter int          SETS      = 64,
  parameter int          POLICY    = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic          clk,
  input logic          reset,
  dcache_repl_if.slave bus
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAY_W-1:0] inv_way;
  logic             has_inv;
  logic [WAY_W-1:0] pol_way;
  logic [WAYS-1:0]  vv;

  // Scan from the top way down so the lowest invalid way is the last one written.
  always_comb begin
    inv_way = '0;
    has_inv = ~&bus.way_valid;
    vv      = bus.way_valid;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vv[WAYS-1]) inv_way = WAY_W'(w);
      vv = vv << 1;
    end
  end

  generate
    if (POLICY == 0) begin : g_rr
      logic [WAY_W-1:0] ptr [SETS];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < SETS; s++) ptr[s] <= '0;
        end else if (bus.touch_valid && bus.touch_fill) begin
          ptr[bus.touch_set] <= bus.touch_way + 1'b1;
        end
      end

      assign pol_way = ptr[bus.victim_set];
    end else if (POLICY == 1) begin : g_plru
      logic [WAYS-2:0]  tree [SETS];
      logic [WAYS-2:0]  cur;
      logic [WAYS-2:0]  upd;
      logic [WAY_W-1:0] vway;
      logic             b;

      // Level d holds nodes 2^d-1 .. 2^(d+1)-2; the way prefix picks the node within a level.
      always_comb begin
        cur  = tree[bus.victim_set];
        vway = '0;
        b    = 1'b0;
        for (int d = 0; d < WAY_W; d++) begin
          b = 1'b0;
          for (int p = 0; p < (1 << d); p++)
            if (int'(vway) == p) b = cur[(1 << d) - 1 + p];
          vway    = vway << 1;
          vway[0] = b;
        end
        pol_way = vway;

        upd = tree[bus.touch_set];
        for (int d = 0; d < WAY_W; d++)
          for (int p = 0; p < (1 << d); p++)
            if (int'(bus.touch_way >> (WAY_W - d)) == p)
              upd[(1 << d) - 1 + p] = ~bus.touch_way[WAY_W-1-d];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < SETS; s++) tree[s] <= '0;
        end else if (bus.touch_valid) begin
          tree[bus.touch_set] <= upd;
        end
      end
    end else begin : g_lfsr
      logic [15:0] lfsr;

      // Right-shifting Fibonacci form of taps 16,14,13,11.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end

      assign pol_way = lfsr[WAY_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.victim_valid <= 1'b0;
      bus.victim_way   <= '0;
    end else begin
      bus.victim_valid <= bus.victim_req;
      if (bus.victim_req) bus.victim_way <= has_inv ? inv_way : pol_way;
    end
  end
endmodule

// File: tb/tb_dcache_repl_policy.sv
// Scoreboard bench: three policy instances driven together, expectations queued at issue, checked by monitors.
module tb_dcache_repl_policy;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dcache_repl_if #(.WAYS(4), .SETS(64)) ip ();
  dcache_repl_if #(.WAYS(4), .SETS(64)) ir ();
  dcache_repl_if #(.WAYS(8), .SETS(64)) il ();

  dcache_repl_policy #(.WAYS(4), .SETS(64), .POLICY(1), .LFSR_SEED(16'hACE1))
    u_plru (.clk(clk), .reset(reset), .bus(ip));
  dcache_repl_policy #(.WAYS(4), .SETS(64), .POLICY(0), .LFSR_SEED(16'hACE1))
    u_rr (.clk(clk), .reset(reset), .bus(ir));
  dcache_repl_policy #(.WAYS(8), .SETS(64), .POLICY(2), .LFSR_SEED(16'hACE1))
    u_lfsr (.clk(clk), .reset(reset), .bus(il));

  int n_tests = 0;
  int n_fail  = 0;

  int q_p[$];
  int q_r[$];
  int q_l[$];
  int fe_p = -1, fe_r = -1, fe_l = -1;

  // Reference state: PLRU as per-way touch timestamps, RR as last filled way, LFSR as an integer.
  int stamp [64][4];
  int stamp_now;
  int last_fill [64];
  int m_lfsr;

  int last_p = 0;
  int n_pulse_l = 0;
  logic [7:0] seen_l = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int low_inv(input logic [7:0] wv, input int ways);
    for (int w = 0; w < ways; w++) if (!wv[w]) return w;
    return -1;
  endfunction

  function automatic int maxst(input int s, input int lo, input int hi);
    int m;
    m = 0;
    for (int w = lo; w < hi; w++) if (stamp[s][w] > m) m = stamp[s][w];
    return m;
  endfunction

  // Descend toward the half whose most recent touch is older; untouched halves tie to the left.
  function automatic int plru_model(input int s);
    int lo, hi, mid;
    lo = 0;
    hi = 4;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (maxst(s, lo, mid) > maxst(s, mid, hi)) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 4; w++) stamp[s][w] = 0;
      last_fill[s] = -1;
    end
    stamp_now = 0;
    m_lfsr = 16'hACE1;
  endtask

  // Predict responses to the inputs currently driven, update the model, then advance one clock.
  task automatic cycle();
    int e, bitv;
    if (reset) begin
      model_reset();
    end else begin
      if (ip.victim_req) begin
        e = low_inv({4'hF, ip.way_valid}, 4);
        if (e < 0) e = plru_model(int'(ip.victim_set));
        if (fe_p >= 0) e = fe_p;
        q_p.push_back(e);
      end
      if (ip.touch_valid) begin
        stamp_now++;
        stamp[int'(ip.touch_set)][int'(ip.touch_way)] = stamp_now;
      end
      if (ir.victim_req) begin
        e = low_inv({4'hF, ir.way_valid}, 4);
        if (e < 0) e = (last_fill[int'(ir.victim_set)] < 0) ? 0 : (last_fill[int'(ir.victim_set)] + 1) % 4;
        if (fe_r >= 0) e = fe_r;
        q_r.push_back(e);
      end
      if (ir.touch_valid && ir.touch_fill) last_fill[int'(ir.touch_set)] = int'(ir.touch_way);
      if (il.victim_req) begin
        e = low_inv(il.way_valid, 8);
        if (e < 0) e = m_lfsr % 8;
        if (fe_l >= 0) e = fe_l;
        q_l.push_back(e);
      end
      bitv = ((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
      m_lfsr = (m_lfsr >> 1) | (bitv << 15);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ip.touch_valid = 0; ip.touch_fill = 0; ip.touch_set = '0; ip.touch_way = '0;
    ip.victim_req = 0;  ip.victim_set = '0; ip.way_valid = '1;
    ir.touch_valid = 0; ir.touch_fill = 0; ir.touch_set = '0; ir.touch_way = '0;
    ir.victim_req = 0;  ir.victim_set = '0; ir.way_valid = '1;
    il.touch_valid = 0; il.touch_fill = 0; il.touch_set = '0; il.touch_way = '0;
    il.victim_req = 0;  il.victim_set = '0; il.way_valid = '1;
    fe_p = -1; fe_r = -1; fe_l = -1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_plru_valid"}, 32'(ip.victim_valid), 0);
    chk({tag, "_plru_way"},   32'(ip.victim_way), 0);
    chk({tag, "_rr_valid"},   32'(ir.victim_valid), 0);
    chk({tag, "_rr_way"},     32'(ir.victim_way), 0);
    chk({tag, "_lfsr_valid"}, 32'(il.victim_valid), 0);
    chk({tag, "_lfsr_way"},   32'(il.victim_way), 0);
  endtask

  always @(negedge clk) begin
    if (reset) last_p = 0;
    else if (ip.victim_valid) begin
      if (q_p.size() == 0) chk("plru_extra_pulse", 32'(ip.victim_valid), 0);
      else chk("plru_victim", 32'(ip.victim_way), q_p.pop_front());
      last_p = int'(ip.victim_way);
    end else begin
      chk("plru_hold", 32'(ip.victim_way), last_p);
    end
  end

  always @(negedge clk) begin
    if (!reset && ir.victim_valid) begin
      if (q_r.size() == 0) chk("rr_extra_pulse", 32'(ir.victim_valid), 0);
      else chk("rr_victim", 32'(ir.victim_way), q_r.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && il.victim_valid) begin
      n_pulse_l++;
      seen_l = seen_l | (8'h01 << il.victim_way);
      if (q_l.size() == 0) chk("lfsr_extra_pulse", 32'(il.victim_valid), 0);
      else chk("lfsr_victim", 32'(il.victim_way), q_l.pop_front());
    end
  end

  initial begin
    clr();
    model_reset();
    repeat (3) cycle();
    chk_outputs_zero("por");
    reset = 0;

    // First requests after reset: PLRU set 5, RR set 7, LFSR seed low bits.
    clr();
    ip.victim_req = 1; ip.victim_set = 5; fe_p = 0;
    ir.victim_req = 1; ir.victim_set = 7; fe_r = 0;
    il.victim_req = 1; fe_l = 1;
    cycle();

    // Hits on PLRU ways 0,2,1; RR fill 0, hit 3, fill 1.
    clr(); ip.touch_valid = 1; ip.touch_set = 5; ip.touch_way = 0;
    ir.touch_valid = 1; ir.touch_fill = 1; ir.touch_set = 7; ir.touch_way = 0; cycle();
    clr(); ip.touch_valid = 1; ip.touch_set = 5; ip.touch_way = 2;
    ir.touch_valid = 1; ir.touch_fill = 0; ir.touch_set = 7; ir.touch_way = 3; cycle();
    clr(); ip.touch_valid = 1; ip.touch_set = 5; ip.touch_way = 1;
    ir.touch_valid = 1; ir.touch_fill = 1; ir.touch_set = 7; ir.touch_way = 1; cycle();

    clr(); ip.victim_req = 1; ip.victim_set = 5; fe_p = 3;
    ir.victim_req = 1; ir.victim_set = 7; fe_r = 2; cycle();
    clr(); ip.victim_req = 1; ip.victim_set = 5; ip.way_valid = 4'b1011; fe_p = 2;
    ir.victim_req = 1; ir.victim_set = 8; fe_r = 0; cycle();
    clr(); ip.victim_req = 1; ip.victim_set = 5; ip.way_valid = 4'b0000; fe_p = 0;
    ir.victim_req = 1; ir.victim_set = 7; ir.way_valid = 4'b1101; fe_r = 1; cycle();
    clr(); ip.touch_valid = 1; ip.touch_set = 5; ip.touch_way = 3; cycle();
    clr(); ip.victim_req = 1; ip.victim_set = 5; fe_p = 0; cycle();

    // Reset lands while a result is in flight: that result must never pulse.
    clr(); ip.victim_req = 1; ip.victim_set = 5;
    ir.victim_req = 1; ir.victim_set = 7; il.victim_req = 1; cycle();
    reset = 1;
    model_reset();
    q_p.delete(); q_r.delete(); q_l.delete();
    clr(); cycle();
    chk_outputs_zero("midrst");
    cycle();
    reset = 0;

    for (int s = 0; s < 64; s++) begin
      clr(); ip.victim_req = 1; ip.victim_set = 6'(s); fe_p = 0;
      ir.victim_req = 1; ir.victim_set = 6'(s); fe_r = 0;
      if (s == 0) begin il.victim_req = 1; fe_l = 1; end
      cycle();
    end

    // Touch and request in the same cycle see pre-touch state.
    clr(); ip.touch_valid = 1; ip.touch_set = 5; ip.touch_way = 0;
    ip.victim_req = 1; ip.victim_set = 5; fe_p = 0; cycle();
    clr(); ip.victim_req = 1; ip.victim_set = 5; fe_p = 2; cycle();

    clr(); repeat (3) cycle();
    n_pulse_l = 0;
    seen_l = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      clr(); il.victim_req = 1; cycle();
    end
    clr(); repeat (3) cycle();
    chk("lfsr_pulses", 32'(n_pulse_l), 1000);
    chk("lfsr_ways_seen", 32'(seen_l), 8'hFF);

    for (int i = 0; i < 600; i++) begin
      clr();
      ip.touch_valid = 1'($urandom_range(0, 1)); ip.touch_fill = 1'($urandom_range(0, 1));
      ip.touch_set = 6'($urandom_range(0, 3)); ip.touch_way = 2'($urandom_range(0, 3));
      ip.victim_req = 1'($urandom_range(0, 1)); ip.victim_set = 6'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ip.way_valid = 4'($urandom);
      ir.touch_valid = 1'($urandom_range(0, 1)); ir.touch_fill = 1'($urandom_range(0, 1));
      ir.touch_set = 6'($urandom_range(0, 3)); ir.touch_way = 2'($urandom_range(0, 3));
      ir.victim_req = 1'($urandom_range(0, 1)); ir.victim_set = 6'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ir.way_valid = 4'($urandom);
      il.touch_valid = 1'($urandom_range(0, 1)); il.touch_way = 3'($urandom_range(0, 7));
      il.victim_req = 1'($urandom_range(0, 1)); il.victim_set = 6'($urandom);
      if ($urandom_range(0, 3) == 0) il.way_valid = 8'($urandom);
      cycle();
    end

    clr(); repeat (3) cycle();
    chk("plru_pending", 32'(q_p.size()), 0);
    chk("rr_pending",   32'(q_r.size()), 0);
    chk("lfsr_pending", 32'(q_l.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_repl_policy.md
# dcache_repl_policy

Parametrised per-set victim-selection unit for the set-associative data cache. It replaces the single-counter replacement ID with per-set state and offers three compile-time policies: round-robin, tree pseudo-LRU, and LFSR random. It also gives invalid ways priority as victims. It sits beside the dCache controller: the controller reports hits and fills as "touches" and requests a victim way on a miss.

## Interface
- WAYS, 4: associativity; power of two, 2..8.
- SETS, 64: number of sets; power of two, 1..256.
- POLICY, 1: 0 = round-robin, 1 = tree PLRU, 2 = LFSR random.
- LFSR_SEED, 16'hACE1: reset value of the random LFSR; must be nonzero.
- Derived: WAY_W = max(1, clog2(WAYS)); IDX_W = max(1, clog2(SETS)).

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- touch_valid  in  1  a hit or fill occurred this cycle.
- touch_fill  in  1  qualifies touch_valid: 1 = line fill, 0 = hit.
- touch_set  in  IDX_W  set of the touch.
- touch_way  in  WAY_W  way hit or filled.
- victim_req  in  1  request a victim for victim_set.
- victim_set  in  IDX_W  set needing a victim.
- way_valid  in  WAYS  valid bits of victim_set's ways, sampled with victim_req.
- victim_valid  out  1  one-cycle pulse, one cycle after victim_req.
- victim_way  out  WAY_W  selected way; held until the next victim_valid.

## Operation
- State per set:
  - POLICY 0: a WAY_W-bit pointer.
  - POLICY 1: a WAYS-1-bit PLRU tree.
  - POLICY 2: no per-set state; one global 16-bit Fibonacci LFSR, taps 16,14,13,11.
- Invalid-way priority, all policies:
  - If way_valid is not all-ones, the victim is the lowest-indexed way with way_valid=0.
  - Policy state is not consulted in that case.
- Round-robin:
  - Victim = pointer[victim_set].
  - A touch with touch_fill=1 sets pointer[touch_set] = (touch_way+1) mod WAYS.
  - Hits do not change the pointer.
- Tree PLRU:
  - Node 0 is the root; node n has children 2n+1 and 2n+2; the leaves map to ways in order.
  - A bit value of 0 means the victim lies in the left subtree, 1 means the right subtree.
  - Victim: walk from the root following the bits.
  - On any touch (hit or fill), every node on the path to touch_way is set to point away from it.
- LFSR:
  - Advances every cycle while not in reset.
  - Victim = lfsr[WAY_W-1:0], sampled in the cycle victim_req is high.
  - Touches have no effect.
- Simultaneous touch and victim_req to the same set: the victim is computed from the pre-touch state; the touch update is applied at the same edge.
- Simultaneous touches are impossible by construction (single touch port).
- victim_req in consecutive cycles is legal. Each request produces its own victim_valid pulse, and results are in request order.
- touch_fill is ignored when touch_valid=0. Out-of-range inputs cannot occur because WAYS and SETS are powers of two.

## Timing
- Victim latency: exactly 1 cycle. victim_req at edge N gives victim_valid=1 and victim_way in cycle N+1, computed from the state and way_valid sampled at edge N.
- Touch update is visible to a victim_req sampled at the edge after the touch.
- Reset values:
  - victim_valid=0, victim_way=0.
  - All RR pointers 0 and all PLRU bits 0, so the first victim with all ways valid is way 0.
  - LFSR = LFSR_SEED.
- Reset asserted mid-operation: an in-flight victim result is dropped (no victim_valid pulse) and all state clears asynchronously. The first request after reset deasserts behaves as after power-up.
- There are no stall inputs; the controller must consume victim_way while victim_valid is high or later; the value stays stable until the next pulse.

## Test plan
- PLRU, WAYS=4, way_valid=4'b1111, set 5:
  - After reset, victim_req -> victim_way=0.
  - Touch ways 0, 2, 1 (hits) -> victim_way=3.
  - Touch 3 -> victim_way=0.
- Invalid priority, PLRU, set 5 state pointing to way 3, way_valid=4'b1011 -> victim_way=2. Repeat with 4'b0000 -> victim_way=0.
- Round-robin, WAYS=4, set 7: fill way 0, fill way 1 -> victim_way=2. A hit on way 3 in between leaves the result at 2. Set 8 is untouched -> victim_way=0.
- Same-cycle touch and request, PLRU, set 5 fresh after reset: touch way 0 and victim_req together -> victim_way=0 (pre-touch). The next request -> victim_way=2.
- LFSR, WAYS=8, LFSR_SEED=16'hACE1: victim_req in the first cycle after reset -> victim_way=3'b001. 1000 back-to-back requests -> 1000 victim_valid pulses and all 8 ways observed.
- Reset mid-flight: assert reset in the cycle after victim_req -> no victim_valid. Outputs are 0 while reset is high; after release, PLRU victim=0 for all sets.
